mem_tid_allocator: RTL and testbench

- Parametrised transaction-ID allocator and outstanding-request tracker on the cache-to-memory interface.
- Arbitrates N requester ports round-robin and hands each granted request a free memory TID.
- Caps in-flight requests at MaxOutstanding and frees TIDs when responses return.
- Serialises non-idempotent requests: drains all outstanding traffic first, then blocks until the non-idempotent request completes.

---
 rtl/mem_tid_allocator.sv | 157 +++++++++++++++
 tb/tb_mem_tid_allocator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_tid_allocator.sv
// mem_tid_allocator: round-robin grant of memory transaction IDs with an
// outstanding-request cap and drain/serialise handling for non-idempotent
// requests. Grant eligibility depends only on registered state, so responses
// never reach gnt_o combinationally.
module mem_tid_allocator #(
    parameter  int NrPorts          = 2,
    parameter  int TidWidth         = 2,
    parameter  int MaxOutstanding   = 4,
    parameter  int NonIdemSerialise = 1,
    localparam int PortW            = (NrPorts > 1) ? $clog2(NrPorts) : 1,
    localparam int CntW             = $clog2(MaxOutstanding + 1),
    localparam int NrTids           = 2 ** TidWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [NrPorts-1:0]  req_valid_i,
    input  logic [NrPorts-1:0]  req_nonidem_i,
    output logic [NrPorts-1:0]  gnt_o,
    output logic [TidWidth-1:0] gnt_tid_o,
    input  logic                rsp_valid_i,
    input  logic [TidWidth-1:0] rsp_tid_i,
    output logic [PortW-1:0]    rsp_port_o,
    output logic                rsp_spurious_o,
    output logic [CntW-1:0]     outstanding_o,
    output logic                idle_o
);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SERIAL = 2'd2;

    logic [NrTids-1:0]   r_busy;
    logic [PortW-1:0]    r_owner [NrTids];
    logic [CntW-1:0]     r_cnt;
    logic [PortW-1:0]    r_rr;
    logic [1:0]          r_state;
    logic [TidWidth-1:0] r_serial_tid;

    logic                w_any_vld;
    logic [PortW-1:0]    w_win;
    logic                w_free_any;
    logic [TidWidth-1:0] w_free_tid;
    logic                w_win_nonidem;
    logic                w_blocked;
    logic                w_gnt;
    logic                w_rel;
    logic                w_enter_drain;
    logic [PortW-1:0]    w_rr_inc;

    // Round-robin search: first valid port at or after r_rr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        w_any_vld = 1'b0;
        w_win     = '0;
        for (int i = 0; i < NrPorts; i++) begin
            j = int'(r_rr) + i;
            if (j >= NrPorts) j = j - NrPorts;
            if (!w_any_vld && req_valid_i[j]) begin
                w_any_vld = 1'b1;
                w_win     = PortW'(j);
            end
        end
    end

    // Lowest-index free TID from the registered bitmap only; a TID being
    // released this cycle is still busy here and becomes eligible next cycle.
    always_comb begin
        w_free_any = 1'b0;
        w_free_tid = '0;
        for (int t = 0; t < NrTids; t++) begin
            if (!w_free_any && !r_busy[t]) begin
                w_free_any = 1'b1;
                w_free_tid = TidWidth'(t);
            end
        end
    end

    assign w_win_nonidem = (NonIdemSerialise != 0) && w_any_vld && req_nonidem_i[w_win];
    // A non-idempotent winner may only go when nothing else is in flight.
    assign w_blocked     = w_win_nonidem && (r_cnt != '0);
    assign w_gnt         = !flush_i && (r_state == ST_NORMAL) && w_any_vld &&
                           (r_cnt < CntW'(MaxOutstanding)) && w_free_any && !w_blocked;
    assign w_enter_drain = !flush_i && (r_state == ST_NORMAL) && w_blocked;
    assign w_rel         = rsp_valid_i && r_busy[rsp_tid_i];
    assign w_rr_inc      = (w_win == PortW'(NrPorts - 1)) ? '0 : w_win + 1'b1;

    // One-hot grant to the round-robin winner.
    always_comb begin
        gnt_o        = '0;
        if (w_gnt) gnt_o[w_win] = 1'b1;
    end

    assign gnt_tid_o      = w_free_tid;
    assign rsp_port_o     = r_owner[rsp_tid_i];
    assign rsp_spurious_o = rsp_valid_i && !r_busy[rsp_tid_i];
    assign outstanding_o  = r_cnt;
    assign idle_o         = (r_cnt == '0) && (r_state == ST_NORMAL);

    // TID bitmap, owner table and in-flight counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_cnt  <= '0;
            for (int t = 0; t < NrTids; t++) r_owner[t] <= '0;
        end else if (flush_i) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            // Granted and released TIDs always differ (free vs busy).
            if (w_rel) r_busy[rsp_tid_i] <= 1'b0;
            if (w_gnt) begin
                r_busy[w_free_tid]  <= 1'b1;
                r_owner[w_free_tid] <= w_win;
            end
            case ({w_gnt, w_rel})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Serialisation FSM and round-robin pointer; rr freezes on a draining
    // non-idempotent winner so the same port wins once traffic has drained.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_NORMAL;
            r_rr         <= '0;
            r_serial_tid <= '0;
        end else if (flush_i) begin
            r_state <= ST_NORMAL;
        end else begin
            if (w_gnt)              r_rr <= w_rr_inc;
            else if (w_enter_drain) r_rr <= w_win;
            case (r_state)
                ST_NORMAL: begin
                    if (w_gnt && w_win_nonidem) begin
                        r_state      <= ST_SERIAL;
                        r_serial_tid <= w_free_tid;
                    end else if (w_enter_drain) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) r_state <= ST_NORMAL;
                end
                ST_SERIAL: begin
                    if (w_rel && (rsp_tid_i == r_serial_tid)) r_state <= ST_NORMAL;
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_tid_allocator.sv
// Directed bench for mem_tid_allocator (2 ports, 4 TIDs, cap 4, serialise on).
module tb_mem_tid_allocator;

    logic       clk;
    logic       rst_ni;
    logic       flush;
    logic [1:0] req_valid;
    logic [1:0] req_nonidem;
    logic [1:0] gnt;
    logic [1:0] gnt_tid;
    logic       rsp_valid;
    logic [1:0] rsp_tid;
    logic [0:0] rsp_port;
    logic       rsp_spurious;
    logic [2:0] outstanding;
    logic       idle;

    int n_chk = 0;
    int n_err = 0;

    mem_tid_allocator #(
        .NrPorts(2), .TidWidth(2), .MaxOutstanding(4), .NonIdemSerialise(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .req_valid_i(req_valid), .req_nonidem_i(req_nonidem),
        .gnt_o(gnt), .gnt_tid_o(gnt_tid),
        .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid),
        .rsp_port_o(rsp_port), .rsp_spurious_o(rsp_spurious),
        .outstanding_o(outstanding), .idle_o(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drv(input logic [1:0] v, input logic [1:0] ni,
                       input logic rv, input logic [1:0] rt, input logic fl);
        req_valid   = v;
        req_nonidem = ni;
        rsp_valid   = rv;
        rsp_tid     = rt;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; flush = 1'b0; req_valid = '0; req_nonidem = '0;
        rsp_valid = 1'b0; rsp_tid = '0;
        #2;
        chk("rst_idle", idle, 1);
        chk("rst_cnt", outstanding, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_spur", rsp_spurious, 0);
        step();
        rst_ni = 1'b1;
        step();

        // Spurious release of free TID 1.
        drv(2'b00, 2'b00, 1'b1, 2'd1, 1'b0);
        chk("spur_hi", rsp_spurious, 1);
        step();
        drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("spur_lo", rsp_spurious, 0);
        chk("spur_cnt", outstanding, 0);

        // Both ports requesting: p0/t0, p1/t1, p0/t2, p1/t3, then full.
        drv(2'b11, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("rr0_gnt", gnt, 2'b01);  chk("rr0_tid", gnt_tid, 0);
        step();
        chk("rr1_gnt", gnt, 2'b10);  chk("rr1_tid", gnt_tid, 1);
        chk("rr1_cnt", outstanding, 1);
        step();
        chk("rr2_gnt", gnt, 2'b01);  chk("rr2_tid", gnt_tid, 2);
        step();
        chk("rr3_gnt", gnt, 2'b10);  chk("rr3_tid", gnt_tid, 3);
        step();
        chk("full_gnt", gnt, 0);
        chk("full_cnt", outstanding, 4);
        chk("full_idle", idle, 0);

        // Full: release TID 2 with p0 requesting; no grant until next cycle.
        drv(2'b01, 2'b00, 1'b1, 2'd2, 1'b0);
        chk("rel2_gnt", gnt, 0);
        chk("rel2_port", rsp_port, 0);
        chk("rel2_spur", rsp_spurious, 0);
        step();
        drv(2'b01, 2'b00, 1'b0, 2'd3, 1'b0);
        chk("rel2_cnt", outstanding, 3);
        chk("regnt_gnt", gnt, 2'b01);
        chk("regnt_tid", gnt_tid, 2);
        chk("own3", rsp_port, 1);
        step();
        chk("regnt_cnt", outstanding, 4);

        // Free TID 1, then grant p1 TID 1 while releasing TID 0 (owner p0).
        drv(2'b00, 2'b00, 1'b1, 2'd1, 1'b0);
        step();
        drv(2'b10, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("swap_gnt", gnt, 2'b10);
        chk("swap_tid", gnt_tid, 1);
        chk("swap_port", rsp_port, 0);
        step();
        drv(2'b00, 2'b00, 1'b0, 2'd1, 1'b0);
        chk("swap_cnt", outstanding, 3);
        chk("swap_own", rsp_port, 1);

        // Flush with TIDs 1,2,3 busy; no grant in the flush cycle.
        drv(2'b01, 2'b00, 1'b0, 2'd0, 1'b1);
        chk("fl_gnt", gnt, 0);
        step();
        drv(2'b00, 2'b00, 1'b1, 2'd1, 1'b0);
        chk("fl_cnt", outstanding, 0);
        chk("fl_idle", idle, 1);
        chk("fl_spur", rsp_spurious, 1);
        step();

        // rr preserved at 0: two p0 grants take TIDs 0,1 and leave rr at 1.
        drv(2'b01, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("pre0_tid", gnt_tid, 0);
        step();
        chk("pre1_gnt", gnt, 2'b01);
        chk("pre1_tid", gnt_tid, 1);
        step();

        // p1 non-idempotent with 2 in flight -> drain.
        drv(2'b11, 2'b10, 1'b0, 2'd0, 1'b0);
        chk("ni_blk", gnt, 0);
        step();
        chk("dr_idle", idle, 0);
        drv(2'b11, 2'b10, 1'b1, 2'd0, 1'b0);
        chk("dr_gnt0", gnt, 0);
        step();
        drv(2'b11, 2'b10, 1'b1, 2'd1, 1'b0);
        chk("dr_cnt1", outstanding, 1);
        chk("dr_gnt1", gnt, 0);
        step();
        drv(2'b11, 2'b10, 1'b0, 2'd0, 1'b0);
        chk("dr_cnt0", outstanding, 0);
        chk("dr_gnt2", gnt, 0);
        step();
        chk("ni_gnt", gnt, 2'b10);
        chk("ni_tid", gnt_tid, 0);
        step();

        // Serialised: p0 blocked until TID 0 returns.
        drv(2'b01, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("ser_cnt", outstanding, 1);
        chk("ser_gnt", gnt, 0);
        step();
        drv(2'b01, 2'b00, 1'b1, 2'd0, 1'b0);
        chk("ser_rel_gnt", gnt, 0);
        chk("ser_rel_port", rsp_port, 1);
        step();
        drv(2'b01, 2'b00, 1'b0, 2'd0, 1'b0);
        chk("post_gnt", gnt, 2'b01);
        chk("post_tid", gnt_tid, 0);
        step();
        chk("post_cnt", outstanding, 1);

        // Asynchronous reset mid-transaction.
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_cnt", outstanding, 0);
        chk("arst_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
